// File: rtl/mux4way_rr.sv
// mux4way_rr
// ----------
// Four-to-one collector. Four source channels, each with a valid/ready
// handshake, are merged onto a single registered output channel. A
// round-robin arbiter chooses which source is served. The chosen word and
// its source index are held in one output register until the sink accepts
// them.
//
// Ports:
//   clk        : system clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   i0..i3     : data words from sources 0..3
//   v0..v3     : source valid flags
//   r0..r3     : source ready flags (combinational, only the granted source)
//   saida      : registered output word
//   sel        : registered index of the source that produced saida
//   valid_out  : saida/sel currently hold a word
//   ready_in   : sink accepts the held word this cycle
module mux4way_rr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             v0,
    input  logic             v1,
    input  logic             v2,
    input  logic             v3,
    output logic             r0,
    output logic             r1,
    output logic             r2,
    output logic             r3,
    output logic [WIDTH-1:0] saida,
    output logic [1:0]       sel,
    output logic             valid_out,
    input  logic             ready_in
);

    // The output slot is either empty or holds one word.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] saida_q, saida_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;

    logic [WIDTH-1:0] in_word [4];
    logic [3:0]       v_vec;
    logic [3:0]       r_vec;
    logic [1:0]       grant;
    logic [1:0]       idx;
    logic             any_valid;
    logic             free;
    logic             src_xfer;
    logic             sink_xfer;

    // Gather the individual source ports into indexable form.
    assign in_word[0] = i0;
    assign in_word[1] = i1;
    assign in_word[2] = i2;
    assign in_word[3] = i3;
    assign v_vec      = {v3, v2, v1, v0};

    // Round-robin search starting at ptr. The loop walks the offsets from
    // farthest to nearest so that the nearest asserted valid is the last
    // one written, which makes it the grant.
    always_comb begin
        grant     = ptr_q;
        idx       = ptr_q;
        any_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (v_vec[idx]) begin
                grant     = idx;
                any_valid = 1'b1;
            end
        end
    end

    // The slot can take a new word when it is empty or is being drained this
    // cycle. Reset suppresses every ready so nothing is accepted while rst=1.
    always_comb begin
        free      = (state_q == EMPTY) || ready_in;
        src_xfer  = free && any_valid && !rst;
        sink_xfer = (state_q == FULL) && ready_in;
        r_vec     = 4'b0000;
        if (src_xfer) begin
            r_vec[grant] = 1'b1;
        end
    end

    assign r0 = r_vec[0];
    assign r1 = r_vec[1];
    assign r2 = r_vec[2];
    assign r3 = r_vec[3];

    // Next-state logic for the output slot. A new word always wins over a
    // drain, so simultaneous sink and source transfers keep the slot full and
    // sustain one word per cycle. A drain alone leaves saida/sel untouched.
    always_comb begin
        state_d = state_q;
        saida_d = saida_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (src_xfer) begin
            state_d = FULL;
            saida_d = in_word[grant];
            sel_d   = grant;
            ptr_d   = grant + 2'd1;
        end else if (sink_xfer) begin
            state_d = EMPTY;
        end
    end

    // State registers with synchronous reset that overrides any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            saida_q <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            saida_q <= saida_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign saida     = saida_q;
    assign sel       = sel_q;
    assign valid_out = (state_q == FULL);

endmodule

// File: doc/mux4way_rr.md
Name: mux4way_rr

Overview:
- Four-to-one collector: the opposite end of the 1-to-4 demux path in trab1.
- Four source channels, each with a valid/ready handshake, are merged onto one output channel.
- A round-robin arbiter picks the source; a single registered output stage holds the chosen word and its source index until the sink accepts it.
- Sits where demuxed lanes are recombined into one stream.

Parameters:
- WIDTH, 4, data width of each input word and of the output word.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- i0  input  WIDTH  data from source 0.
- i1  input  WIDTH  data from source 1.
- i2  input  WIDTH  data from source 2.
- i3  input  WIDTH  data from source 3.
- v0  input  1  source 0 valid.
- v1  input  1  source 1 valid.
- v2  input  1  source 2 valid.
- v3  input  1  source 3 valid.
- r0  output  1  source 0 ready; combinational, true only for the granted source.
- r1  output  1  source 1 ready; combinational, true only for the granted source.
- r2  output  1  source 2 ready; combinational, true only for the granted source.
- r3  output  1  source 3 ready; combinational, true only for the granted source.
- saida  output  WIDTH  registered output word.
- sel  output  2  registered index of the source that produced saida.
- valid_out  output  1  registered; saida/sel hold a word.
- ready_in  input  1  sink accepts the word this cycle.

Behaviour:
- Reset (rst=1 at a rising edge):
  - valid_out=0, saida=0, sel=0, ptr=0.
  - Any held word is discarded.
  - r0..r3 are 0 while rst=1.
- States, derived from valid_out:
  - EMPTY (valid_out=0).
  - FULL (valid_out=1).
- Slot free condition: free = !valid_out || ready_in.
- Arbitration (combinational):
  - Search v[ptr], v[ptr+1], v[ptr+2], v[ptr+3], indices mod 4.
  - The first asserted valid is the grant g.
  - No valid means no grant.
- Ready generation:
  - r_g = free && any-valid; all other r_k = 0.
  - A source transfer occurs when v_k && r_k.
- On a source transfer, at the next edge:
  - saida <= i_g, sel <= g, valid_out <= 1, ptr <= (g+1) mod 4.
- On a sink transfer (valid_out && ready_in) with no source transfer in the same cycle:
  - valid_out <= 0.
  - saida and sel keep their last value.
- Simultaneous sink and source transfer:
  - The new word replaces the old one at that edge.
  - valid_out stays 1.
  - Sustains one word per cycle.
- FULL with ready_in=0:
  - saida, sel and valid_out are frozen; all r_k = 0; ptr unchanged.
- Latency: a word presented while the slot is free appears on saida one cycle later.
- Fairness: a continuously asserted source waits at most 3 grants before its own.
- Source side rules:
  - v_k must not depend combinationally on r_k.
  - i_k must be stable while v_k=1 and no transfer has occurred.
  - The block does not check these rules.
- ptr wraps 3 -> 0.
- sel is 2 bits; there is no out-of-range case.
- rst has priority over every transfer in the same cycle.

Test Plan:
- Single source, EMPTY start: v1=1, i1=4'hA, ready_in=1 for one cycle.
  - That cycle: r1=1.
  - Next cycle: saida=A, sel=1, valid_out=1, ptr=2.
- All four valid continuously, ready_in=1, after reset:
  - Grants in order 0,1,2,3,0,...
  - One word per cycle on saida.
  - sel sequence 0,1,2,3,0.
- Backpressure: capture i2=4'h5, then hold ready_in=0 for 5 cycles with v0=v3=1.
  - saida=5, sel=2, valid_out=1 stay frozen.
  - r0..r3=0 throughout.
  - On ready_in=1: r3=1 (ptr=3) before source 0.
- Round-robin skip: ptr=3, only v0 and v2 asserted.
  - Grant 0, then ptr=1, then grant 2.
- Drain: FULL, ready_in=1, all v=0.
  - Next cycle valid_out=0.
  - saida and sel retain their last values.
- Reset mid-operation: FULL with saida=7, sel=3, ptr=0; assert rst for one cycle with v0=1 and ready_in=1.
  - Next cycle valid_out=0, saida=0, sel=0, ptr=0.
  - r0=0 during reset; no transfer is accepted.
